// File: rtl/nnrv_pkg.sv
// Shared definitions for the instruction/data bus arbiter: FSM state encoding
// and default widths.
package nnrv_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_XLEN       = 32;
    localparam int DEF_STARVE_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/nnrv_arb_prio.sv
// Fetch/load-store priority decision. MEM wins by default; with
// NNRV_ARB_STARVE_EN defined a saturating counter forces an IF grant after
// STARVE_MAX consecutive MEM grants made while IF was waiting.
import nnrv_pkg::*;

module nnrv_arb_prio #(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
`ifdef NNRV_ARB_STARVE_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic if_req,
    input  logic mem_req,
    output logic grant_if,
    output logic grant_mem
);

`ifdef NNRV_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved   = (starve_cnt == CW'(STARVE_MAX));
    assign grant_mem = arb_en & mem_req & ~(if_req & starved);
    assign grant_if  = arb_en & if_req & ~grant_mem;

    // Only MEM grants that actually held IF off count toward starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_mem && if_req && !starved) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    assign grant_mem = arb_en & mem_req;
    assign grant_if  = arb_en & if_req & ~mem_req;
`endif

endmodule

// File: rtl/nnrv_bus_arb.sv
// Shares one memory port between instruction fetch and load/store. Each access
// is a single bus transaction followed by one IDLE cycle.
import nnrv_pkg::*;

module nnrv_bus_arb #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int XLEN       = DEF_XLEN,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic [XLEN-1:0]       o_if_rdata,
    output logic                  o_if_valid,
    input  logic                  i_mem_req,
    input  logic                  i_mem_we,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [XLEN-1:0]       i_mem_wdata,
    output logic                  o_mem_gnt,
    output logic [XLEN-1:0]       o_mem_rdata,
    output logic                  o_mem_valid,
    output logic                  o_bus_ce,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [XLEN-1:0]       o_bus_wdata,
    input  logic [XLEN-1:0]       i_bus_rdata,
    input  logic                  i_bus_ready
);

    arb_state_t state, state_n;
    logic       arb_en, grant_if, grant_mem;

    assign arb_en = (state == ST_IDLE);

    nnrv_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
`ifdef NNRV_ARB_STARVE_EN
        .clk       (i_clk),
        .rst       (i_rst),
`endif
        .arb_en    (arb_en),
        .if_req    (i_if_req),
        .mem_req   (i_mem_req),
        .grant_if  (grant_if),
        .grant_mem (grant_mem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (grant_mem)     state_n = ST_BUSY_MEM;
                else if (grant_if) state_n = ST_BUSY_IF;
            end
            ST_BUSY_IF, ST_BUSY_MEM: begin
                if (i_bus_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Bus and response registers; addr/we/wdata stay put after completion,
    // only o_bus_ce qualifies them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_if_gnt    <= 1'b0;
            o_if_valid  <= 1'b0;
            o_if_rdata  <= '0;
            o_mem_gnt   <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_rdata <= '0;
            o_bus_ce    <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else begin
            o_if_gnt    <= 1'b0;
            o_if_valid  <= 1'b0;
            o_mem_gnt   <= 1'b0;
            o_mem_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_mem) begin
                        o_mem_gnt   <= 1'b1;
                        o_bus_ce    <= 1'b1;
                        o_bus_we    <= i_mem_we;
                        o_bus_addr  <= i_mem_addr;
                        o_bus_wdata <= i_mem_wdata;
                    end else if (grant_if) begin
                        o_if_gnt    <= 1'b1;
                        o_bus_ce    <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= i_if_addr;
                        o_bus_wdata <= '0;
                    end
                end
                ST_BUSY_IF: begin
                    if (i_bus_ready) begin
                        o_if_rdata <= i_bus_rdata;
                        o_if_valid <= 1'b1;
                        o_bus_ce   <= 1'b0;
                    end
                end
                ST_BUSY_MEM: begin
                    if (i_bus_ready) begin
                        if (!o_bus_we) o_mem_rdata <= i_bus_rdata;
                        o_mem_valid <= 1'b1;
                        o_bus_ce    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nnrv_bus_arb.md
NNRV_BUS_ARB -- requirements
Module: nnrv_bus_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the address width of both requesters and the shared bus.
REQ-002 Parameter XLEN, default 32, sets the data width.
REQ-003 Parameter STARVE_MAX, default 3, is the number of consecutive MEM grants allowed while IF waits.
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_if_req  in  1  fetch request; held until o_if_gnt.
REQ-007 i_if_addr  in  ADDR_WIDTH  fetch address.
REQ-008 o_if_gnt  out  1  one-cycle pulse: fetch accepted.
REQ-009 o_if_rdata  out  XLEN  fetched word.
REQ-010 o_if_valid  out  1  one-cycle pulse: o_if_rdata valid.
REQ-011 i_mem_req  in  1  load/store request; held until o_mem_gnt.
REQ-012 i_mem_we  in  1  1 = store, 0 = load.
REQ-013 i_mem_addr  in  ADDR_WIDTH  data address.
REQ-014 i_mem_wdata  in  XLEN  store data.
REQ-015 o_mem_gnt  out  1  one-cycle pulse: load/store accepted.
REQ-016 o_mem_rdata  out  XLEN  load data.
REQ-017 o_mem_valid  out  1  one-cycle pulse: load/store complete.
REQ-018 o_bus_ce  out  1  shared-memory access active.
REQ-019 o_bus_we  out  1  shared-memory write enable.
REQ-020 o_bus_addr  out  ADDR_WIDTH  shared-memory address.
REQ-021 o_bus_wdata  out  XLEN  shared-memory write data.
REQ-022 i_bus_rdata  in  XLEN  shared-memory read data; sampled when i_bus_ready=1.
REQ-023 i_bus_ready  in  1  memory completes the current access this cycle.

Function
REQ-024 The FSM SHALL have states IDLE, BUSY_IF and BUSY_MEM.
REQ-025 In IDLE with any request present, it SHALL move to BUSY_IF or BUSY_MEM next cycle per REQ-026, pulse that requester's gnt, and register the winner's addr/we/wdata onto the bus with o_bus_ce=1 in that same cycle.
REQ-026 Arbitration SHALL grant MEM over IF when both request, except as modified by REQ-036.
REQ-027 In BUSY_x, bus outputs SHALL be held stable until the cycle i_bus_ready=1.
REQ-028 On i_bus_ready=1 in BUSY_x, the FSM SHALL capture i_bus_rdata into o_x_rdata (loads/fetches only), pulse o_x_valid next cycle, drop o_bus_ce next cycle, and return to IDLE.
REQ-029 Minimum latency SHALL be: req at cycle N, gnt and o_bus_ce at N+1, ready at N+1, valid at N+2.
REQ-030 One IDLE cycle SHALL separate consecutive bus accesses.
REQ-031 On a store completion, o_mem_rdata SHALL retain its previous value and o_mem_valid SHALL still pulse.
REQ-032 i_bus_ready in IDLE SHALL be ignored.
REQ-033 Requests arriving in BUSY_x SHALL wait; a requester SHALL NOT receive a second gnt before its own valid.
REQ-034 o_bus_we SHALL be 0 for every IF access.

Reset
REQ-035 While i_rst=1 the block SHALL enter IDLE, clear any in-flight access without producing valid, and drive every output to 0 (gnt, valid, rdata, bus_ce, bus_we, bus_addr, bus_wdata); the starvation counter SHALL be 0.

Configuration
REQ-036 With NNRV_ARB_STARVE_EN defined, a counter SHALL increment on each MEM grant made while i_if_req=1, clear on each IF grant, and saturate at STARVE_MAX; when it equals STARVE_MAX, the next arbitration SHALL grant IF.
REQ-037 Without NNRV_ARB_STARVE_EN, the counter SHALL be absent and MEM priority SHALL be strict.

Structure
REQ-038 FSM state encoding and the default widths SHALL reside in the shared package nnrv_pkg.
REQ-039 Arbitration decision and starvation counter SHALL form sub-module nnrv_arb_prio; the FSM and bus registers SHALL stay in nnrv_bus_arb.

Verification
REQ-040 Single IF request, addr 0x10, ready held 1: gnt at N+1; valid at N+2 with rdata = bus data 0x00000013.
REQ-041 IF and MEM requests in the same cycle, MEM load addr 0x20: MEM granted first; IF granted in the IDLE cycle after MEM valid.
REQ-042 MEM store, addr 0x30, wdata 0xDEADBEEF, ready delayed 3 cycles: bus outputs stable for 4 cycles, o_bus_we=1, valid pulses once, o_mem_rdata unchanged.
REQ-043 With NNRV_ARB_STARVE_EN and STARVE_MAX=3, both requesting continuously: grant order MEM,MEM,MEM,IF,MEM,...; without the macro, IF is never granted.
REQ-044 i_rst asserted while in BUSY_MEM with ready low: next cycle all outputs 0, no valid pulse, FSM in IDLE; a fresh request after reset is granted normally.
